stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Controls the exam stopwatch: start/stop, lap freeze, clear and saturation.
//  Contains its own prescaler, which emits a 1-cycle tick enable at TICK_HZ, gated by the FSM.
//  Holds the live MM:SS.CC count in BCD and drives the display value, live or frozen lap.
//  Sits between the debounced button pulses and the 7-segment multiplexer. Single clock domain.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  TICK_HZ  100         count resolution (centiseconds); DIV = CLK_HZ/TICK_HZ, DIV >= 2
//  MAX_MIN  59          highest minute value before saturation (0..99)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  start_stop in   1  1-cycle pulse: toggle run/pause
//  lap        in   1  1-cycle pulse: freeze/unfreeze display while running
//  clear      in   1  1-cycle pulse: return to zero
//  tick       out  1  1-cycle prescaler terminal pulse (count advance strobe)
//  running    out  1  1 in RUN or LAP
//  lap_active out  1  1 in LAP
//  sat        out  1  1 in DONE (count saturated)
//  min_bcd    out  8  displayed minutes, 2 BCD digits
//  sec_bcd    out  8  displayed seconds, 2 BCD digits (00..59)
//  cs_bcd     out  8  displayed centiseconds, 2 BCD digits (00..99)
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, live count=00:00.00, lap reg=0, all outputs 0.
//  Prescaler: counter width ceil(log2(DIV)). Increments only in RUN/LAP.
//   At DIV-1: wraps to 0 and tick=1 for that cycle.
//   Holds its value in PAUSE, so resume keeps the partial tick.
//   Cleared on clear and on entry to IDLE.
//  Count: on tick, cs+1. cs 99->00 carries to sec. sec 59->00 carries to min.
//   All digit updates are in the same cycle. Every digit stays valid BCD.
//  States and transitions (evaluated each clk):
//   IDLE : start_stop->RUN; lap ignored
//   RUN  : start_stop->PAUSE; lap->LAP, lap reg <= live count (same cycle)
//   LAP  : counting continues; lap->RUN; start_stop->PAUSE (lap freeze dropped)
//   PAUSE: start_stop->RUN; lap ignored
//   DONE : entered when a tick would advance past MAX_MIN:59.99.
//          Count holds MAX_MIN:59.99; start_stop/lap ignored.
//   Any state: clear->IDLE, count=0, lap reg=0.
//  Priority on simultaneous pulses: clear > start_stop > lap.
//  Tick and start_stop in the same cycle: the tick increment is applied, then the state changes.
//  Display mux: lap reg in LAP, live count in all other states.
//   The mux is registered: 1 clk latency from count/lap reg to *_bcd.
//  Status outputs (running, lap_active, sat) are decoded from the state register (no extra latency).
//  Reset mid-count: everything returns to reset values on the next evaluation; no partial tick survives.
// TESTING  (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, MAX_MIN=1)
//  1 reset, start_stop -> tick every 10 clks; after 250 clks cs_bcd=8'h25, sec=0, running=1
//  2 run to 100 ticks -> cs_bcd=8'h00, sec_bcd=8'h01 (carry in same cycle as tick)
//  3 pause at prescaler=4, wait 1000 clks, resume -> next tick after exactly 6 clks, count unchanged while paused
//  4 lap at 00:03.17 -> display frozen at 03.17 while live advances; lap again -> display shows live value 1 clk later
//  5 run to 01:59.99 + 1 tick -> sat=1, running=0, display 01:59.99; start_stop ignored; clear -> IDLE, all zeros
//  6 clear+start_stop same cycle -> IDLE, zeros; async rst mid-LAP -> all outputs 0 immediately

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Exam stopwatch controller: prescaler, run/pause/lap/done FSM, BCD MM:SS.CC count.
// The display value is registered, so *_bcd trails the count and lap register by one clock.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic       tick,
  output logic       running,
  output logic       lap_active,
  output logic       sat,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [3:0] MAX_M1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_M0 = 4'(MAX_MIN % 10);

  typedef enum logic [2:0] {IDLE, RUN, LAP, PAUSE, DONE} state_t;

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] cs1;
    logic [3:0] cs0;
  } bcd_t;

  state_t        state, next_state;
  logic [PW-1:0] presc;
  bcd_t          count, lap_reg, disp;
  logic          at_max, lap_cap;

  // Ripple carry through all six digits within one cycle.
  function automatic bcd_t bcd_inc(input bcd_t c);
    bcd_t n;
    n = c;
    if (c.cs0 != 4'd9) n.cs0 = c.cs0 + 4'd1;
    else begin
      n.cs0 = 4'd0;
      if (c.cs1 != 4'd9) n.cs1 = c.cs1 + 4'd1;
      else begin
        n.cs1 = 4'd0;
        if (c.sec0 != 4'd9) n.sec0 = c.sec0 + 4'd1;
        else begin
          n.sec0 = 4'd0;
          if (c.sec1 != 4'd5) n.sec1 = c.sec1 + 4'd1;
          else begin
            n.sec1 = 4'd0;
            if (c.min0 != 4'd9) n.min0 = c.min0 + 4'd1;
            else begin
              n.min0 = 4'd0;
              n.min1 = c.min1 + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  assign at_max = (count == {MAX_M1, MAX_M0, 16'h5999});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A saturating tick wins over start_stop/lap because the increment is applied first.
  always_comb begin
    next_state = state;
    if (clear) next_state = IDLE;
    else begin
      case (state)
        IDLE, PAUSE: if (start_stop) next_state = RUN;
        RUN: begin
          if (tick && at_max)  next_state = DONE;
          else if (start_stop) next_state = PAUSE;
          else if (lap)        next_state = LAP;
        end
        LAP: begin
          if (tick && at_max)  next_state = DONE;
          else if (start_stop) next_state = PAUSE;
          else if (lap)        next_state = RUN;
        end
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    running    = 1'b0;
    lap_active = 1'b0;
    sat        = 1'b0;
    case (state)
      RUN:     running = 1'b1;
      LAP:     begin running = 1'b1; lap_active = 1'b1; end
      DONE:    sat = 1'b1;
      default: ;
    endcase
    tick = running && (presc == PMAX);
  end

  assign lap_cap = (state == RUN) && (next_state == LAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      lap_reg <= '0;
    end else if (clear) begin
      presc   <= '0;
      count   <= '0;
      lap_reg <= '0;
    end else begin
      if (running) presc <= tick ? '0 : presc + PW'(1);
      if (tick && !at_max) count <= bcd_inc(count);
      if (lap_cap) lap_reg <= count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp <= '0;
    else     disp <= (state == LAP) ? lap_reg : count;
  end

  assign min_bcd = {disp.min1, disp.min0};
  assign sec_bcd = {disp.sec1, disp.sec0};
  assign cs_bcd  = {disp.cs1, disp.cs0};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a centisecond-total model.
module tb_stopwatch_ctrl;
  localparam int CLK_HZ  = 300;
  localparam int TICK_HZ = 100;
  localparam int MAX_MIN = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MAXT    = MAX_MIN * 6000 + 5999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic       tick, running, lap_active, sat;
  logic [7:0] min_bcd, sec_bcd, cs_bcd;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .tick(tick), .running(running), .lap_active(lap_active), .sat(sat),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .cs_bcd(cs_bcd)
  );

  always #5 clk = ~clk;

  // Model: elapsed time as a centisecond total, plus counting/lap/saturated flags.
  bit m_cnt = 0, m_lapf = 0, m_sat = 0, m_hit = 0, m_tk = 0, m_was = 0;
  int m_ph = 0, m_tot = 0, m_lapv = 0, m_disp = 0, m_old = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_lapf = 0; m_sat = 0; m_ph = 0; m_tot = 0; m_lapv = 0; m_disp = 0;
    end else begin
      m_tk   = m_cnt && (m_ph == DIV - 1);
      m_disp = (m_cnt && m_lapf) ? m_lapv : m_tot;
      if (clear) begin
        m_cnt = 0; m_lapf = 0; m_sat = 0; m_ph = 0; m_tot = 0; m_lapv = 0;
      end else begin
        m_was = m_cnt;
        m_old = m_tot;
        m_hit = 0;
        if (m_cnt) m_ph = (m_ph + 1) % DIV;
        if (m_tk) begin
          if (m_tot == MAXT) begin
            m_hit = 1; m_sat = 1; m_cnt = 0; m_lapf = 0;
          end else m_tot = m_tot + 1;
        end
        if (!m_hit) begin
          if (m_was) begin
            if (start_stop) begin m_cnt = 0; m_lapf = 0; end
            else if (lap) begin
              if (!m_lapf) m_lapv = m_old;
              m_lapf = !m_lapf;
            end
          end else if (!m_sat && start_stop) m_cnt = 1;
        end
      end
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("tick", tick, m_cnt && (m_ph == DIV - 1));
      chk("running", running, m_cnt);
      chk("lap_active", lap_active, m_cnt && m_lapf);
      chk("sat", sat, m_sat);
      chk("min_bcd", min_bcd, to_bcd(m_disp / 6000));
      chk("sec_bcd", sec_bcd, to_bcd((m_disp / 100) % 60));
      chk("cs_bcd", cs_bcd, to_bcd(m_disp % 100));
    end
  end

  task automatic pulse_ss();
    start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; @(negedge clk); lap = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen, cyc;
    seen = 0; cyc = 0;
    while (seen < n && cyc < n * DIV + 50) begin
      @(negedge clk);
      cyc++;
      if (tick) seen++;
    end
    chk("tick_wait", seen, n);
  endtask

  initial begin
    int n, guard;
    logic [7:0] snap_cs, snap_sec;

    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_status", {running, lap_active, sat}, 3'b000);
    chk("rst_display", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);
    rst = 1'b0;
    chk_en = 1'b1;

    pulse_ss();
    wait_ticks(25);
    repeat (2) @(negedge clk);
    chk("t1_cs", cs_bcd, 8'h25);
    chk("t1_sec", sec_bcd, 8'h00);
    chk("t1_running", running, 1);

    wait_ticks(75);
    repeat (2) @(negedge clk);
    chk("t2_cs", cs_bcd, 8'h00);
    chk("t2_sec", sec_bcd, 8'h01);

    // Pause with one partial prescaler step held, then resume.
    guard = 0;
    while (m_ph != 0 && guard < 20) begin @(negedge clk); guard++; end
    pulse_ss();
    @(negedge clk);
    snap_cs = cs_bcd; snap_sec = sec_bcd;
    n = 0;
    repeat (100) begin @(negedge clk); if (tick) n++; end
    chk("pause_ticks", n, 0);
    chk("pause_cs_hold", cs_bcd, snap_cs);
    chk("pause_sec_hold", sec_bcd, snap_sec);
    start_stop = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start_stop = 1'b0;
      n++;
    end while (!tick && n < 20);
    chk("resume_tick_delay", n, 2);

    guard = 0;
    while (m_tot != 317 && guard < 3000) begin @(negedge clk); guard++; end
    pulse_lap();
    chk("lap_frozen_sec", sec_bcd, 8'h03);
    chk("lap_frozen_cs", cs_bcd, 8'h17);
    wait_ticks(10);
    chk("lap_held_sec", sec_bcd, 8'h03);
    chk("lap_held_cs", cs_bcd, 8'h17);
    chk("lap_active_on", lap_active, 1);
    pulse_lap();
    chk("lap_active_off", lap_active, 0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      start_stop = ($urandom_range(0, 39) == 0);
      lap        = ($urandom_range(0, 29) == 0);
      clear      = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

    pulse_clear();
    pulse_ss();
    guard = 0;
    while (!sat && guard < 40000) begin @(negedge clk); guard++; end
    chk("sat_reached", sat, 1);
    @(negedge clk);
    chk("sat_running", running, 0);
    chk("sat_display", {min_bcd, sec_bcd, cs_bcd}, 24'h015999);
    pulse_ss();
    pulse_lap();
    repeat (5) @(negedge clk);
    chk("sat_sticky", {sat, running, lap_active}, 3'b100);
    chk("sat_display_hold", {min_bcd, sec_bcd, cs_bcd}, 24'h015999);
    pulse_clear();
    chk("clear_from_done", {sat, running}, 2'b00);
    @(negedge clk);
    chk("clear_display", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);

    pulse_ss();
    repeat (20) @(negedge clk);
    clear = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_stop = 1'b0;
    chk("clear_ss_running", running, 0);
    @(negedge clk);
    chk("clear_ss_display", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);

    pulse_ss();
    repeat (40) @(negedge clk);
    pulse_lap();
    repeat (10) @(negedge clk);
    chk("pre_rst_lap", lap_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_status", {tick, running, lap_active, sat}, 4'b0000);
    chk("async_rst_display", {min_bcd, sec_bcd, cs_bcd}, 24'h000000);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
